// File: rtl/exp4_unidade_controle_pkg.sv
// Shared definitions for the Experiment 4 control unit: state codes (also shown
// on the debug 7-seg display), the output bundle and its decode from state, and
// the default wait-timeout length used when EXP4_TIMEOUT_EN is defined.
package exp4_unidade_controle_pkg;

   // Default number of cycles allowed in espera before giving up (must be >= 2).
   localparam int TIMEOUT_CYCLES_DEFAULT = 3000;

   // State codes double as the db_estado debug value.
   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARACAO  = 4'h1,
      ESPERA      = 4'h2,
      REGISTRA    = 4'h4,
      COMPARACAO  = 4'h5,
      PROXIMO     = 4'h6,
      FIM_ACERTOU = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_ERROU   = 4'hE
   } estado_t;

   // Moore outputs common to every build; timeout is handled separately in the top.
   typedef struct packed {
      logic zera_c;
      logic conta_c;
      logic zera_r;
      logic registra_r;
      logic pronto;
      logic acertou;
      logic errou;
   } saidas_t;

   // Output decode for a given state.
   function automatic saidas_t decodifica(input estado_t e);
      saidas_t s;
      s = '0;
      case (e)
         PREPARACAO:  begin s.zera_c = 1'b1; s.zera_r = 1'b1; end
         REGISTRA:    s.registra_r = 1'b1;
         PROXIMO:     s.conta_c    = 1'b1;
         FIM_ACERTOU: begin s.pronto = 1'b1; s.acertou = 1'b1; end
         FIM_ERROU:   begin s.pronto = 1'b1; s.errou   = 1'b1; end
         FIM_TIMEOUT: s.pronto = 1'b1;
         default:     ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/exp4_contador_timeout.sv
// Wait counter for the espera state: synchronous clear, free increment otherwise,
// and a terminal flag when the count reaches TIMEOUT_CYCLES-1.
// Only present when EXP4_TIMEOUT_EN is defined.
`ifdef EXP4_TIMEOUT_EN
module exp4_contador_timeout
   import exp4_unidade_controle_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)(
   input  logic clock,
   input  logic reset,
   input  logic i_limpa,
   output logic o_fim
);

   localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [W-1:0] r_contagem;

   // Count every cycle unless reset or told to clear.
   always_ff @(posedge clock) begin
      if (!reset || i_limpa) r_contagem <= '0;
      else                   r_contagem <= r_contagem + W'(1);
   end

   assign o_fim = (r_contagem == W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/exp4_unidade_controle.sv
// Control unit for the Experiment 4 memory-sequence game: a Moore FSM that
// sequences one round of 16 plays against the data-flow block and reports
// hit/miss. Define EXP4_TIMEOUT_EN to add the espera timeout (fim_timeout state).
module exp4_unidade_controle
   import exp4_unidade_controle_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada_feita,
   input  logic       igual,
   input  logic       fimC,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   estado_t r_estado;
   estado_t w_proximo;
   saidas_t r_saidas;

`ifdef EXP4_TIMEOUT_EN
   logic w_limpa_espera;
   logic w_fim_espera;
   logic r_timeout;

   // The counter only runs while waiting for a play.
   assign w_limpa_espera = (r_estado != ESPERA);

   exp4_contador_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_contador_timeout (
      .clock   (clock),
      .reset   (reset),
      .i_limpa (w_limpa_espera),
      .o_fim   (w_fim_espera)
   );
`endif

   // Next-state logic; strobes arriving outside espera are simply not looked at.
   always_comb begin
      // NOTE: default assignment first so every path writes w_proximo and no latch is inferred.
      w_proximo = r_estado;
      case (r_estado)
         INICIAL:     if (iniciar) w_proximo = PREPARACAO;
         PREPARACAO:  w_proximo = ESPERA;
         ESPERA: begin
            if (jogada_feita) w_proximo = REGISTRA;
`ifdef EXP4_TIMEOUT_EN
            else if (w_fim_espera) w_proximo = FIM_TIMEOUT;
`endif
         end
         REGISTRA:    w_proximo = COMPARACAO;
         COMPARACAO: begin
            if (!igual)     w_proximo = FIM_ERROU;
            else if (fimC)  w_proximo = FIM_ACERTOU;
            else            w_proximo = PROXIMO;
         end
         PROXIMO:     w_proximo = ESPERA;
         FIM_ACERTOU: if (iniciar) w_proximo = PREPARACAO;
         FIM_ERROU:   if (iniciar) w_proximo = PREPARACAO;
`ifdef EXP4_TIMEOUT_EN
         FIM_TIMEOUT: if (iniciar) w_proximo = PREPARACAO;
`endif
         default:     w_proximo = INICIAL;
      endcase
   end

   // State register with outputs registered from the next state, so they track the state exactly.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      if (!reset) begin
         r_estado <= INICIAL;
         r_saidas <= '0;
`ifdef EXP4_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
      end else begin
         r_estado <= w_proximo;
         r_saidas <= decodifica(w_proximo);
`ifdef EXP4_TIMEOUT_EN
         r_timeout <= (w_proximo == FIM_TIMEOUT);
`endif
      end
   end

   assign zeraC     = r_saidas.zera_c;
   assign contaC    = r_saidas.conta_c;
   assign zeraR     = r_saidas.zera_r;
   assign registraR = r_saidas.registra_r;
   assign pronto    = r_saidas.pronto;
   assign acertou   = r_saidas.acertou;
   assign errou     = r_saidas.errou;
   assign db_estado = r_estado;

`ifdef EXP4_TIMEOUT_EN
   assign timeout = r_timeout;
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Testbench for exp4_unidade_controle. Stimulus queues the expected output
// vector for each clock edge; a monitor pops and compares after every edge.
// Timeout scenarios run only when EXP4_TIMEOUT_EN is defined (TIMEOUT_CYCLES=5).
module tb_exp4_unidade_controle;

   // Expected state codes, written out independently of the design package.
   localparam logic [3:0] S_INI = 4'h0;
   localparam logic [3:0] S_PRE = 4'h1;
   localparam logic [3:0] S_ESP = 4'h2;
   localparam logic [3:0] S_REG = 4'h4;
   localparam logic [3:0] S_CMP = 4'h5;
   localparam logic [3:0] S_PRX = 4'h6;
   localparam logic [3:0] S_ACE = 4'hA;
   localparam logic [3:0] S_TMO = 4'hD;
   localparam logic [3:0] S_ERR = 4'hE;

   typedef struct {
      string      nome;
      logic [11:0] valor;
   } esperado_t;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic       jogada_feita;
   logic       igual;
   logic       fimC;
   logic       zeraC;
   logic       contaC;
   logic       zeraR;
   logic       registraR;
   logic       pronto;
   logic       acertou;
   logic       errou;
   logic       timeout;
   logic [3:0] db_estado;

   logic [11:0] w_obs;

   esperado_t fila[$];
   int        n_checks   = 0;
   int        n_falhas   = 0;
   int        n_conta    = 0;
   int        n_registra = 0;

   exp4_unidade_controle #(.TIMEOUT_CYCLES(5)) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .jogada_feita (jogada_feita),
      .igual        (igual),
      .fimC         (fimC),
      .zeraC        (zeraC),
      .contaC       (contaC),
      .zeraR        (zeraR),
      .registraR    (registraR),
      .pronto       (pronto),
      .acertou      (acertou),
      .errou        (errou),
      .timeout      (timeout),
      .db_estado    (db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign w_obs = {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};

   // Reference output vector for a state, from the state/output table.
   function automatic logic [11:0] modelo(input logic [3:0] s);
      logic [7:0] f;
      case (s)
         S_PRE:   f = 8'b1010_0000;
         S_REG:   f = 8'b0001_0000;
         S_PRX:   f = 8'b0100_0000;
         S_ACE:   f = 8'b0000_1100;
         S_ERR:   f = 8'b0000_1010;
         S_TMO:   f = 8'b0000_1001;
         default: f = 8'b0000_0000;
      endcase
      return {s, f};
   endfunction

   task automatic check(input string nome, input logic [11:0] obtido, input logic [11:0] esperado);
      n_checks++;
      if (obtido !== esperado) begin
         n_falhas++;
         $display("FAIL %s: obtido=%h esperado=%h", nome, obtido, esperado);
      end
   endtask

   // Drive inputs for the next edge and queue the outputs that edge must produce.
   task automatic passo(input logic rst, input logic ini, input logic jog, input logic ig,
                        input logic fim, input logic [3:0] est, input string nome);
      esperado_t e;
      @(negedge clock);
      reset        = rst;
      iniciar      = ini;
      jogada_feita = jog;
      igual        = ig;
      fimC         = fim;
      e.nome  = nome;
      e.valor = modelo(est);
      fila.push_back(e);
   endtask

   task automatic ocioso(input logic [3:0] est, input string nome);
      passo(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, est, nome);
   endtask

   // One play from espera: strobe, registra, comparacao, result.
   task automatic jogada(input logic ig, input logic fim, input logic [3:0] resultado,
                         input logic lixo, input string nome);
      passo(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S_REG, {nome, "_reg"});
      passo(1'b1, 1'b0, lixo, 1'b0, 1'b0, S_CMP, {nome, "_cmp"});
      passo(1'b1, 1'b0, 1'b0, ig, fim, resultado, {nome, "_res"});
   endtask

   // Monitor: compare after every edge while expectations are pending.
   initial begin
      esperado_t e;
      forever begin
         @(posedge clock);
         #2;
         if (fila.size() > 0) begin
            e = fila.pop_front();
            check(e.nome, w_obs, e.valor);
         end
      end
   end

   // Pulse counters for contaC and registraR.
   always @(posedge clock) begin
      #2;
      if (contaC === 1'b1)    n_conta++;
      if (registraR === 1'b1) n_registra++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulacao nao terminou");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0; igual = 1'b0; fimC = 1'b0;

      // Reset held two cycles, with start/strobe asserted to show they are ignored.
      passo(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, S_INI, "reset0");
      passo(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_INI, "reset1");
      ocioso(S_INI, "inicial_parado");

      // Start: preparacao for exactly one cycle, then espera.
      @(negedge clock);
      n_conta = 0;
      passo(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_PRE, "prep");
      ocioso(S_ESP, "espera0");
      ocioso(S_ESP, "espera1");

      // Full win: 16 plays, fimC only on the last; stray inputs in registra/proximo/espera.
      for (int i = 0; i < 16; i++) begin
         jogada(1'b1, (i == 15), (i == 15) ? S_ACE : S_PRX, (i == 0), $sformatf("v%0d", i));
         if (i < 15) begin
            passo(1'b1, 1'b0, (i == 1), 1'b0, 1'b0, S_ESP, $sformatf("v%0d_esp", i));
            if (i == 3) passo(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_ESP, "ini_em_espera");
         end
      end
      ocioso(S_ACE, "acertou_fica");
      check("contaC_vitoria", 12'(n_conta), 12'd15);

      // New round, miss on the 3rd play (igual=0 wins over fimC=1).
      @(negedge clock);
      n_conta = 0;
      passo(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_PRE, "prep2");
      ocioso(S_ESP, "espera2");
      for (int i = 0; i < 2; i++) begin
         jogada(1'b1, 1'b0, S_PRX, 1'b0, $sformatf("e%0d", i));
         ocioso(S_ESP, $sformatf("e%0d_esp", i));
      end
      jogada(1'b0, 1'b1, S_ERR, 1'b0, "e2");
      ocioso(S_ERR, "errou_fica");
      check("contaC_erro", 12'(n_conta), 12'd2);
      passo(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_PRE, "prep_pos_erro");
      ocioso(S_ESP, "espera3");

      // Mid-round reset while in comparacao.
      passo(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S_REG, "mr_reg");
      passo(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_CMP, "mr_cmp");
      @(negedge clock);
      n_conta = 0;
      n_registra = 0;
      passo(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_INI, "mr_reset");
      passo(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, S_INI, "mr_apos0");
      passo(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, S_INI, "mr_apos1");
      ocioso(S_INI, "mr_apos2");
      @(negedge clock);
      check("mr_contaC", 12'(n_conta), 12'd0);
      check("mr_registraR", 12'(n_registra), 12'd0);

`ifdef EXP4_TIMEOUT_EN
      // Idle in espera: fim_timeout on the 5th edge after entering espera.
      passo(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_PRE, "t_prep");
      ocioso(S_ESP, "t_esp0");
      for (int i = 1; i < 5; i++) ocioso(S_ESP, $sformatf("t_esp%0d", i));
      ocioso(S_TMO, "t_timeout");
      ocioso(S_TMO, "t_timeout_fica");
      // Strobe in the terminal cycle: the play wins.
      passo(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_PRE, "t2_prep");
      ocioso(S_ESP, "t2_esp0");
      for (int i = 1; i < 5; i++) ocioso(S_ESP, $sformatf("t2_esp%0d", i));
      passo(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, S_REG, "t2_reg");
      passo(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_CMP, "t2_cmp");
      passo(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_ERR, "t2_err");
`endif

      @(posedge clock);
      #4;
      check("fila_vazia", 12'(fila.size()), 12'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_falhas);
      $finish;
   end

endmodule
